psk_link_ctrl: RTL and testbench

Link sequencer for the PSK modem. It owns the run-time configuration of the Tx and Rx datapaths (mode, delay, NCO phase increment, loop shifts) and applies every configuration change safely: it drains the in-flight Tx frame, holds the datapath in reset, loads the new settings, and waits for the Rx loop to report lock. It sits between the host/register interface and the `Tx`/`Rx` instances, all in the 32.768 MHz domain.

---
 rtl/psk_pkg.sv | 30 +++
 rtl/psk_link_ctrl_if.sv | 22 ++
 rtl/psk_cycle_timer.sv | 27 ++
 rtl/psk_link_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_psk_link_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psk_pkg.sv
// Shared definitions for the PSK link controller: mode codes, FSM encoding and the
// configuration record applied to the Tx/Rx datapaths.
package psk_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StSettle = 3'd1,
        StLock   = 3'd2,
        StRun    = 3'd3,
        StDrain  = 3'd4,
        StFail   = 3'd5
    } psk_state_e;

    typedef struct packed {
        logic [3:0]  mode;
        logic [3:0]  delay;
        logic [15:0] phase;
        logic [3:0]  fb;
        logic [3:0]  gd;
    } psk_cfg_t;

    function automatic logic mode_legal(input logic [3:0] mode);
        return (mode == MODE_BPSK) || (mode == MODE_QPSK) || (mode == MODE_MIX);
    endfunction

endpackage

// File: rtl/psk_link_ctrl_if.sv
// Configuration request channel between the host register block and psk_link_ctrl.
interface psk_link_ctrl_if;

    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_mode;
    logic [3:0]  cfg_delay;
    logic [15:0] cfg_phase;
    logic [3:0]  cfg_fb_shift;
    logic [3:0]  cfg_gd_shift;

    modport master (
        output cfg_valid, cfg_mode, cfg_delay, cfg_phase, cfg_fb_shift, cfg_gd_shift,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_delay, cfg_phase, cfg_fb_shift, cfg_gd_shift,
        output cfg_ready
    );

endinterface

// File: rtl/psk_cycle_timer.sv
// Loadable 16-bit down-counter that saturates at zero; done is high while the count is zero.
module psk_cycle_timer (
    input  logic        clk_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    output logic        done_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // No reset of its own: the owner holds load_i high while in reset.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == 16'd0);

endmodule

// File: rtl/psk_link_ctrl.sv
// PSK link sequencer: drains Tx, resets the datapath, applies new settings and waits for lock.
// Optional watchdog relock in RUN is enabled by defining PSK_CTRL_WATCHDOG_EN.
module psk_link_ctrl
    import psk_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 256,
    parameter int unsigned DRAIN_MAX    = 4096,
    parameter int unsigned LOCK_PULSES  = 32,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned WDOG_CYCLES  = 4096,
    parameter logic [3:0]  DEF_MODE     = 4'b0001,
    parameter logic [3:0]  DEF_DELAY    = 4'd8,
    parameter logic [15:0] DEF_PHASE    = 16'd8208,
    parameter logic [3:0]  DEF_FB       = 4'd0,
    parameter logic [3:0]  DEF_GD       = 4'd3
) (
    input  logic               clk_32M768,
    input  logic               rst_n_32M768,
    psk_link_ctrl_if.slave     cfg,
    input  logic               tx_tvalid,
    input  logic               tx_tlast,
    input  logic               rx_valid,
    output logic [3:0]         MODE_CTRL,
    output logic [3:0]         DELAY_CNT,
    output logic [15:0]        TX_PHASE_CONFIG,
    output logic [3:0]         FEEDBACK_SHIFT,
    output logic [3:0]         GARDNER_SHIFT,
    output logic               dp_rst_n,
    output logic               tx_enable,
    output logic               locked,
    output logic               cfg_err,
    output logic               lock_fail,
    output logic [2:0]         state
);

    localparam psk_cfg_t DEF_CFG = '{
        mode:  DEF_MODE,
        delay: DEF_DELAY,
        phase: DEF_PHASE,
        fb:    DEF_FB,
        gd:    DEF_GD
    };
    localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'd15;
    localparam logic [15:0] DRAIN_LOAD  = 16'(DRAIN_MAX - 1);
    localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] PULSE_LAST  = 16'(LOCK_PULSES - 1);

    psk_state_e  state_q, state_d;
    psk_cfg_t    shadow_q, shadow_d;
    psk_cfg_t    applied_q, applied_d;
    logic [15:0] pulse_cnt_q, pulse_cnt_d;
    logic        entered_q, entered_d;
    logic        dp_rst_n_q, dp_rst_n_d;
    logic        tx_enable_q, tx_enable_d;
    logic        locked_q, locked_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        cfg_err_q, cfg_err_d;
    logic        lock_fail_q, lock_fail_d;

    logic handshake, req_legal;
    logic phase_load, phase_done, lock_done, drain_done, wdog_fire;
    logic [15:0] phase_val;

    assign handshake = cfg.cfg_valid && cfg_ready_q;
    assign req_legal = mode_legal(cfg.cfg_mode);

    // One timer covers both RESET and SETTLE; it is reloaded on every state change.
    assign phase_load = !rst_n_32M768 || (state_d != state_q);
    assign phase_val  = (rst_n_32M768 && state_d == StSettle) ? SETTLE_LOAD : RST_LOAD;

    psk_cycle_timer u_phase_timer (
        .clk_i      (clk_32M768),
        .load_i     (phase_load),
        .load_val_i (phase_val),
        .done_o     (phase_done)
    );

    psk_cycle_timer u_lock_timer (
        .clk_i      (clk_32M768),
        .load_i     (state_q != StLock),
        .load_val_i (LOCK_LOAD),
        .done_o     (lock_done)
    );

    psk_cycle_timer u_drain_timer (
        .clk_i      (clk_32M768),
        .load_i     (state_q != StDrain),
        .load_val_i (DRAIN_LOAD),
        .done_o     (drain_done)
    );

`ifdef PSK_CTRL_WATCHDOG_EN
    logic wdog_done;

    psk_cycle_timer u_wdog_timer (
        .clk_i      (clk_32M768),
        .load_i     ((state_q != StRun) || rx_valid),
        .load_val_i (16'(WDOG_CYCLES - 1)),
        .done_o     (wdog_done)
    );

    assign wdog_fire = wdog_done;
`else
    assign wdog_fire = (WDOG_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  if (phase_done) state_d = StSettle;
            StSettle: if (phase_done) state_d = StLock;
            StLock: begin
                if (rx_valid && pulse_cnt_q == PULSE_LAST) begin
                    state_d = StRun;
                end else if (lock_done) begin
                    state_d = StFail;
                end
            end
            StRun:    if ((handshake && req_legal) || wdog_fire) state_d = StDrain;
            // An idle Tx stream on entry means there is no frame to wait for.
            StDrain: begin
                if ((tx_tvalid && tx_tlast) || drain_done || (entered_q && !tx_tvalid)) begin
                    state_d = StReset;
                end
            end
            StFail:   if (handshake && req_legal) state_d = StReset;
            default:  state_d = StReset;
        endcase
    end

    always_comb begin
        dp_rst_n_d  = (state_d != StReset);
        tx_enable_d = (state_d == StRun);
        locked_d    = (state_d == StRun);
        cfg_ready_d = (state_d == StRun) || (state_d == StFail);
        entered_d   = (state_d != state_q);

        cfg_err_d = cfg_err_q;
        if (handshake) cfg_err_d = !req_legal;

        lock_fail_d = lock_fail_q;
        if (state_q == StLock && state_d == StFail) lock_fail_d = 1'b1;
        if (state_q == StLock && state_d == StRun)  lock_fail_d = 1'b0;

        shadow_d = shadow_q;
        if (handshake && req_legal) begin
            shadow_d = '{
                mode:  cfg.cfg_mode,
                delay: cfg.cfg_delay,
                phase: cfg.cfg_phase,
                fb:    cfg.cfg_fb_shift,
                gd:    cfg.cfg_gd_shift
            };
        end

        applied_d = applied_q;
        if (state_q == StReset && entered_q) applied_d = shadow_q;

        pulse_cnt_d = 16'd0;
        if (state_q == StLock) begin
            pulse_cnt_d = pulse_cnt_q;
            if (rx_valid && pulse_cnt_q != 16'hFFFF) pulse_cnt_d = pulse_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            shadow_q    <= DEF_CFG;
            applied_q   <= DEF_CFG;
            pulse_cnt_q <= 16'd0;
            entered_q   <= 1'b1;
            dp_rst_n_q  <= 1'b0;
            tx_enable_q <= 1'b0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            applied_q   <= applied_d;
            pulse_cnt_q <= pulse_cnt_d;
            entered_q   <= entered_d;
            dp_rst_n_q  <= dp_rst_n_d;
            tx_enable_q <= tx_enable_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign cfg.cfg_ready     = cfg_ready_q;
    assign MODE_CTRL         = applied_q.mode;
    assign DELAY_CNT         = applied_q.delay;
    assign TX_PHASE_CONFIG   = applied_q.phase;
    assign FEEDBACK_SHIFT    = applied_q.fb;
    assign GARDNER_SHIFT     = applied_q.gd;
    assign dp_rst_n          = dp_rst_n_q;
    assign tx_enable         = tx_enable_q;
    assign locked            = locked_q;
    assign cfg_err           = cfg_err_q;
    assign lock_fail         = lock_fail_q;
    assign state             = state_q;

endmodule

// File: tb/tb_psk_link_ctrl.sv
// Directed bench for psk_link_ctrl: power-up, mode switch, illegal mode, lock timeout,
// drain timeout, mid-operation reset and (with PSK_CTRL_WATCHDOG_EN) watchdog relock.
module tb_psk_link_ctrl;

    logic        clk_32M768;
    logic        rst_n_32M768;
    logic        tx_tvalid, tx_tlast, rx_valid;
    logic [3:0]  MODE_CTRL, DELAY_CNT, FEEDBACK_SHIFT, GARDNER_SHIFT;
    logic [15:0] TX_PHASE_CONFIG;
    logic        dp_rst_n, tx_enable, locked, cfg_err, lock_fail;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    psk_link_ctrl_if cfg_if ();

    psk_link_ctrl u_dut (
        .clk_32M768      (clk_32M768),
        .rst_n_32M768    (rst_n_32M768),
        .cfg             (cfg_if),
        .tx_tvalid       (tx_tvalid),
        .tx_tlast        (tx_tlast),
        .rx_valid        (rx_valid),
        .MODE_CTRL       (MODE_CTRL),
        .DELAY_CNT       (DELAY_CNT),
        .TX_PHASE_CONFIG (TX_PHASE_CONFIG),
        .FEEDBACK_SHIFT  (FEEDBACK_SHIFT),
        .GARDNER_SHIFT   (GARDNER_SHIFT),
        .dp_rst_n        (dp_rst_n),
        .tx_enable       (tx_enable),
        .locked          (locked),
        .cfg_err         (cfg_err),
        .lock_fail       (lock_fail),
        .state           (state)
    );

    initial begin
        clk_32M768 = 1'b0;
        forever #5 clk_32M768 = ~clk_32M768;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_32M768);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle configuration request; caller ensures cfg_ready is high.
    task automatic req(input logic [3:0] mode, input logic [3:0] delay,
                       input logic [15:0] phase, input logic [3:0] fb, input logic [3:0] gd);
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_mode     = mode;
        cfg_if.cfg_delay    = delay;
        cfg_if.cfg_phase    = phase;
        cfg_if.cfg_fb_shift = fb;
        cfg_if.cfg_gd_shift = gd;
        step(1);
        cfg_if.cfg_valid    = 1'b0;
    endtask

    // n rx_valid strobes, one every 32 clocks.
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            step(1);
            rx_valid = 1'b0;
            step(31);
        end
    endtask

    // From the first observed RESET cycle minus `pre` clocks already spent: reach RUN.
    task automatic relock(input int pre);
        step(272 - pre);
        chk("relock_in_lock", 32'(state), 32'd2);
        pulses(31);
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        chk("relock_run", 32'(state), 32'd3);
    endtask

    initial begin
        rst_n_32M768        = 1'b0;
        tx_tvalid           = 1'b0;
        tx_tlast            = 1'b0;
        rx_valid            = 1'b0;
        cfg_if.cfg_valid    = 1'b0;
        cfg_if.cfg_mode     = 4'd0;
        cfg_if.cfg_delay    = 4'd0;
        cfg_if.cfg_phase    = 16'd0;
        cfg_if.cfg_fb_shift = 4'd0;
        cfg_if.cfg_gd_shift = 4'd0;
        step(3);

        // Reset values
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mode", 32'(MODE_CTRL), 32'd1);
        chk("rst_delay", 32'(DELAY_CNT), 32'd8);
        chk("rst_phase", 32'(TX_PHASE_CONFIG), 32'd8208);
        chk("rst_fb", 32'(FEEDBACK_SHIFT), 32'd0);
        chk("rst_gd", 32'(GARDNER_SHIFT), 32'd3);
        chk("rst_flags", {26'd0, dp_rst_n, tx_enable, locked, cfg_if.cfg_ready, cfg_err,
                          lock_fail}, 32'd0);

        // Power-up: dp_rst_n rises at clock 256, then 16 settle clocks, then 32 strobes
        rst_n_32M768 = 1'b1;
        step(255);
        chk("pu_dp_rst_low", 32'(dp_rst_n), 32'd0);
        step(1);
        chk("pu_dp_rst_high", 32'(dp_rst_n), 32'd1);
        chk("pu_settle", 32'(state), 32'd1);
        step(15);
        chk("pu_settle_end", 32'(state), 32'd1);
        step(1);
        chk("pu_lock", 32'(state), 32'd2);
        pulses(31);
        chk("pu_not_locked_31", 32'(locked), 32'd0);
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        chk("pu_locked", 32'(locked), 32'd1);
        chk("pu_tx_enable", 32'(tx_enable), 32'd1);
        chk("pu_run_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("pu_run", 32'(state), 32'd3);

        // Illegal mode in RUN
        req(4'b0011, 4'd2, 16'd1234, 4'd1, 4'd1);
        chk("ill_cfg_err", 32'(cfg_err), 32'd1);
        chk("ill_state", 32'(state), 32'd3);
        chk("ill_mode", 32'(MODE_CTRL), 32'd1);
        chk("ill_phase", 32'(TX_PHASE_CONFIG), 32'd8208);
        chk("ill_locked", 32'(locked), 32'd1);

        // Mode switch during a Tx frame; tlast 40 clocks after the handshake cycle
        tx_tvalid = 1'b1;
        req(4'b0010, 4'd5, 16'd8192, 4'd2, 4'd4);
        chk("sw_tx_enable", 32'(tx_enable), 32'd0);
        chk("sw_drain", 32'(state), 32'd4);
        chk("sw_locked", 32'(locked), 32'd0);
        chk("sw_err_clr", 32'(cfg_err), 32'd0);
        step(39);
        chk("sw_still_drain", 32'(state), 32'd4);
        tx_tlast = 1'b1;
        step(1);
        tx_tlast  = 1'b0;
        tx_tvalid = 1'b0;
        chk("sw_reset", 32'(state), 32'd0);
        chk("sw_dp_rst", 32'(dp_rst_n), 32'd0);
        chk("sw_mode_old", 32'(MODE_CTRL), 32'd1);
        step(1);
        chk("sw_mode_new", 32'(MODE_CTRL), 32'd2);
        chk("sw_phase_new", 32'(TX_PHASE_CONFIG), 32'd8192);
        chk("sw_cfg_rest", {20'd0, DELAY_CNT, FEEDBACK_SHIFT, GARDNER_SHIFT}, 32'h524);
        step(254);
        chk("sw_dp_rst_hold", 32'(dp_rst_n), 32'd0);
        step(1);
        chk("sw_dp_rst_rise", 32'(dp_rst_n), 32'd1);
        step(16);
        chk("to_lock", 32'(state), 32'd2);

        // Lock timeout: no rx_valid
        step(65534);
        chk("to_still_lock", 32'(state), 32'd2);
        chk("to_no_fail_yet", 32'(lock_fail), 32'd0);
        step(1);
        chk("to_fail", 32'(state), 32'd5);
        chk("to_lock_fail", 32'(lock_fail), 32'd1);
        chk("to_fail_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("to_fail_dp", 32'(dp_rst_n), 32'd1);
        chk("to_fail_txen", 32'(tx_enable), 32'd0);

        // Illegal (zero) mode in FAIL, then a legal one goes straight to RESET
        req(4'b0000, 4'd0, 16'd0, 4'd0, 4'd0);
        chk("fail_ill_err", 32'(cfg_err), 32'd1);
        chk("fail_ill_state", 32'(state), 32'd5);
        req(4'b0100, 4'd6, 16'd100, 4'd3, 4'd2);
        chk("fail_to_reset", 32'(state), 32'd0);
        chk("fail_err_clr", 32'(cfg_err), 32'd0);
        chk("fail_sticky", 32'(lock_fail), 32'd1);
        step(1);
        chk("fail_mode", 32'(MODE_CTRL), 32'd4);
        chk("fail_phase", 32'(TX_PHASE_CONFIG), 32'd100);
        relock(1);
        chk("relock_fail_clr", 32'(lock_fail), 32'd0);
        chk("relock_locked", 32'(locked), 32'd1);

        // Drain timeout: frame never ends
        tx_tvalid = 1'b1;
        req(4'b0001, 4'd8, 16'd7, 4'd0, 4'd3);
        chk("dt_drain", 32'(state), 32'd4);
        step(4095);
        chk("dt_still_drain", 32'(state), 32'd4);
        step(1);
        chk("dt_reset", 32'(state), 32'd0);
        tx_tvalid = 1'b0;
        step(1);
        chk("dt_phase", 32'(TX_PHASE_CONFIG), 32'd7);

        // Reset asserted in LOCK restores defaults on the next edge
        step(271);
        chk("mr_lock", 32'(state), 32'd2);
        rst_n_32M768 = 1'b0;
        step(1);
        rst_n_32M768 = 1'b1;
        chk("mr_state", 32'(state), 32'd0);
        chk("mr_phase", 32'(TX_PHASE_CONFIG), 32'd8208);
        chk("mr_dp_rst", 32'(dp_rst_n), 32'd0);
        relock(0);
        chk("mr_shadow_default", 32'(TX_PHASE_CONFIG), 32'd8208);

        // Idle Tx on DRAIN entry: RESET on the next cycle
        req(4'b0010, 4'd1, 16'd555, 4'd1, 4'd1);
        chk("idle_drain", 32'(state), 32'd4);
        step(1);
        chk("idle_reset", 32'(state), 32'd0);
        step(1);
        chk("idle_phase", 32'(TX_PHASE_CONFIG), 32'd555);

`ifdef PSK_CTRL_WATCHDOG_EN
        // Watchdog: rx_valid stops in RUN
        relock(1);
        step(4095);
        chk("wd_still_locked", 32'(locked), 32'd1);
        step(1);
        chk("wd_unlocked", 32'(locked), 32'd0);
        chk("wd_drain", 32'(state), 32'd4);
        step(1);
        chk("wd_reset", 32'(state), 32'd0);
        step(1);
        chk("wd_mode_kept", 32'(MODE_CTRL), 32'd2);
        chk("wd_phase_kept", 32'(TX_PHASE_CONFIG), 32'd555);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
